cs_window_filter: RTL
=====================

Name: cs_window_filter

Overview:
- Parametrised successor to the CS block: a streaming approximate-average smoother over a sliding window of WIN samples.
- For each accepted sample with a full window, it computes Xappr, the largest window sample not exceeding the window mean. It then outputs Y = (sum + WIN*Xappr) / (WIN-1).
- Adds a valid handshake, a synchronous flush, generic data width and generic window length (WIN = 2^LOG2_DIV + 1).
- Sits between the sample source and downstream filter/checker logic in the cell-based design.

Parameters:
DATA_W, 8, input sample width (unsigned)
LOG2_DIV, 3, log2 of divisor; window length WIN = 2**LOG2_DIV + 1 (default 9); legal range 1..5
OUT_W, DATA_W+2, output width; fixed by formula, not to be overridden

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset; 0 clears all state immediately
flush  input  1  synchronous clear of window, sum and fill count
in_valid  input  1  X carries a new sample this cycle
X  input  DATA_W  unsigned sample
out_valid  output  1  one-cycle pulse, Y valid
Y  output  OUT_W  filtered result

Behaviour:
- Reset (reset=0, async):
  - window registers, running sum, fill count, pipeline valid, out_valid and Y all go to 0.
  - Normal operation resumes at the first clk edge after reset returns to 1.
- Stage 1, on a posedge with in_valid=1:
  - Window shifts: newest sample enters, oldest is discarded.
  - Running sum updates as sum + X - oldest. Width is DATA_W + LOG2_DIV + 1, no overflow possible.
  - Fill count increments and saturates at WIN.
- in_valid=0: window, sum and fill count hold; no output is produced for that cycle.
- Stage 2, combinational from stage-1 registers:
  - Xi qualifies iff Xi*WIN <= sum. This uses an exact integer comparison; no divider.
  - Xappr = maximum qualifying Xi. At least one Xi always qualifies (the minimum is never above the mean).
  - Ties and duplicate values are irrelevant because only the value matters.
  - T = sum + WIN*Xappr, computed at full width. Y_next = T >> LOG2_DIV (truncation).
- Stage 2 registration:
  - Y and out_valid register at the posedge following the stage-1 update. The registered validity condition is: sample accepted AND fill count reached WIN after that acceptance.
  - Latency: sample accepted at edge N produces out_valid=1 and Y after edge N+1, a 2-cycle input-to-output delay.
- Output rules:
  - out_valid is high exactly one cycle per qualifying accepted sample.
  - Y holds its last value while out_valid=0.
  - Back-to-back in_valid gives one output per cycle (throughput 1).
- Fill boundary:
  - The first WIN-1 accepted samples after reset or flush produce no out_valid.
  - Sample number WIN produces the first result.
- Flush (sync):
  - At the posedge, window, sum and fill count go to 0, and the pending stage-2 valid is cancelled, so no out_valid in the next cycle.
  - Y keeps its value.
  - flush and in_valid in the same cycle: flush wins and the sample is discarded.
- Reset mid-stream: any partially filled window and in-flight result are lost. The window must refill with WIN samples before the next out_valid.

Optional Feature:
- Macro CS_WINDOW_ROUND_EN.
- Defined: Y_next = (T + 2^(LOG2_DIV-1)) >> LOG2_DIV, i.e. round half up. The result never exceeds OUT_W bits.
- Undefined: truncating shift as above.
- Handshake and latency are identical in both builds.

Test Plan:
- Reset high, feed 9 samples all 100 on consecutive cycles -> out_valid only on the cycle 2 after the 9th accept; Xappr=100, Y=225 (both builds).
- Window 1,2,...,9 -> sum 45, Xappr 5, Y=11 (truncated 11.25; rounded 11). Then feed 10 -> window 2..10, sum 54, Xappr 6, Y=13 on the next cycle.
- Window eight 0s then 90 -> sum 90, Xappr=0 (90 excluded), Y=11. Then nine 255s -> Y=573 truncating, 574 with CS_WINDOW_ROUND_EN.
- Interleave in_valid=0 gaps between samples -> no out_valid during gaps; results identical to the gap-free run, each delayed by the gap length.
- After a full window, assert flush together with in_valid=1 and X=50 -> sample dropped, no out_valid next cycle. 8 further samples -> no output; the 9th gives the first new out_valid.
- Drop reset to 0 asynchronously mid-cycle after 5 samples -> out_valid=0 and Y=0 immediately. Release reset and feed 9 samples of 100 -> Y=225 only after the 9th.

Source files
------------

// File: rtl/cs_window_filter.sv
// cs_window_filter: streaming approximate-average smoother over a sliding
// window of WIN = 2**LOG2_DIV + 1 unsigned samples.
//
// For every accepted sample that completes a full window, Xappr is the largest
// window sample not exceeding the window mean. The block then outputs
//   Y = (sum + WIN*Xappr) >> LOG2_DIV.
//
// Handshake: in_valid=1 on a rising clk edge means X is consumed at that edge.
// There is no back-pressure. out_valid is a one-cycle pulse and Y is
// meaningful only while it is high; Y holds its last value otherwise. An
// accepted sample that completes a full window produces its pulse after the
// following edge, so the input-to-output delay is two cycles.
//
// Optional build macro CS_WINDOW_ROUND_EN: when defined, Y is rounded half up
// instead of truncated. Handshake and latency are the same in both builds.
// LOG2_DIV must be in the range 1..5.
module cs_window_filter #(
  parameter  int DATA_W   = 8,
  parameter  int LOG2_DIV = 3,
  localparam int OUT_W    = DATA_W + 2
) (
  input  logic              clk,
  input  logic              reset,      // asynchronous, active low
  input  logic              flush,      // synchronous clear of window state
  input  logic              in_valid,
  input  logic [DATA_W-1:0] X,
  output logic              out_valid,
  output logic [OUT_W-1:0]  Y
);

  localparam int WIN   = (1 << LOG2_DIV) + 1;
  localparam int SUM_W = DATA_W + LOG2_DIV + 1;  // holds WIN * max sample
  localparam int T_W   = SUM_W + 1;              // holds sum + WIN*Xappr
  localparam int CNT_W = $clog2(WIN + 1);

  localparam logic [SUM_W-1:0] WIN_S = SUM_W'(WIN);
  localparam logic [T_W-1:0]   WIN_T = T_W'(WIN);
  localparam logic [CNT_W-1:0] WIN_C = CNT_W'(WIN);

  // Stage-1 state: r_win[0] is the newest sample, r_win[WIN-1] the oldest.
  logic [DATA_W-1:0] r_win [WIN];
  logic [SUM_W-1:0]  r_sum;
  logic [CNT_W-1:0]  r_fill;
  logic              r_pend;     // stage-1 holds a result that should be emitted

  // Stage-2 state.
  logic              r_out_valid;
  logic [OUT_W-1:0]  r_y;

  logic [CNT_W-1:0]  w_fill_next;
  logic [SUM_W-1:0]  w_sum_next;
  logic [DATA_W-1:0] w_xappr;
  logic [T_W-1:0]    w_t;
  logic [T_W-1:0]    w_t_adj;
  logic [OUT_W-1:0]  w_y_next;
  logic              w_emit;

  // Fill count saturates at WIN; running sum adds newest and drops oldest.
  always_comb begin
    w_fill_next = (r_fill == WIN_C) ? WIN_C : r_fill + CNT_W'(1);
    w_sum_next  = r_sum + SUM_W'(X) - SUM_W'(r_win[WIN-1]);
  end

  // Stage 1: window shift, running sum, fill count and pending-result flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIN; i++) r_win[i] <= '0;
      r_sum  <= '0;
      r_fill <= '0;
      r_pend <= 1'b0;
    end else if (flush) begin
      // Flush wins over a simultaneous sample, which is discarded.
      for (int i = 0; i < WIN; i++) r_win[i] <= '0;
      r_sum  <= '0;
      r_fill <= '0;
      r_pend <= 1'b0;
    end else if (in_valid) begin
      r_win[0] <= X;
      for (int i = 1; i < WIN; i++) r_win[i] <= r_win[i-1];
      r_sum  <= w_sum_next;
      r_fill <= w_fill_next;
      r_pend <= (w_fill_next == WIN_C);
    end else begin
      r_pend <= 1'b0;
    end
  end

  // Xappr: largest sample whose value times WIN does not exceed the sum,
  // i.e. the largest sample not above the mean, found without a divider.
  // The window minimum always qualifies, so a zero start value is safe.
  always_comb begin
    w_xappr = '0;
    for (int i = 0; i < WIN; i++) begin
      if ((SUM_W'(r_win[i]) * WIN_S) <= r_sum && r_win[i] > w_xappr) begin
        w_xappr = r_win[i];
      end
    end
  end

  // Result: T = sum + WIN*Xappr at full width, then divide by 2**LOG2_DIV.
  always_comb begin
    w_t = T_W'(r_sum) + (T_W'(w_xappr) * WIN_T);
`ifdef CS_WINDOW_ROUND_EN
    w_t_adj = w_t + T_W'(1 << (LOG2_DIV - 1));
`else
    w_t_adj = w_t;
`endif
    w_y_next = w_t_adj[T_W-1:LOG2_DIV];
  end

  // A flush on the edge that would register a result cancels it.
  assign w_emit = r_pend & ~flush;

  // Stage 2: register the pulse and the result; Y holds between pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
    end else begin
      r_out_valid <= w_emit;
      if (w_emit) r_y <= w_y_next;
    end
  end

  assign out_valid = r_out_valid;
  assign Y         = r_y;

endmodule
